// File: rtl/ir_pkg.sv
// ir_pkg: shared state encoding and default sizing for the IR presence counter
package ir_pkg;
  typedef enum logic [1:0] {IDLE, CONFIRM, PRESENT, RELEASE} ir_presence_state_t;
  localparam int unsigned IR_CONFIRM_CYCLES = 1000;
  localparam int unsigned IR_RELEASE_CYCLES = 1000;
  localparam int unsigned IR_COUNT_W = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with sync clear (clear-then-increment) and sticky saturation flag
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  logic [W-1:0] cnt_q, cnt_d, base;
  logic sat_q, sat_d;
  // clear first, then increment unless already at all-ones; flag sets on reaching all-ones
  always_comb begin
    base = clr ? '0 : cnt_q;
    cnt_d = (inc && base != '1) ? base + W'(1) : base;
    sat_d = (!clr && sat_q) || cnt_d == '1;
  end
  // count and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end
  assign cnt = cnt_q;
  assign sat = sat_q;
endmodule

// File: rtl/ir_presence_counter.sv
// ir_presence_counter: debounced IR presence, per-object event/count, optional dwell timing (IR_PRESENCE_DWELL_EN)
module ir_presence_counter
  import ir_pkg::*;
#(
  parameter int unsigned CONFIRM_CYCLES = IR_CONFIRM_CYCLES,
  parameter int unsigned RELEASE_CYCLES = IR_RELEASE_CYCLES,
  parameter int unsigned COUNT_W = IR_COUNT_W,
  parameter int unsigned TIMER_W = 16,
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ir_detected,
  input  logic               clear,
  output logic               present,
  output logic               led,
  output logic               obj_event,
  output logic [COUNT_W-1:0] obj_count,
  output logic               count_sat,
  output logic [DWELL_W-1:0] dwell_cycles,
  output logic               dwell_valid
);
  ir_presence_state_t state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic present_q, present_d, obj_event_q, obj_event_d, confirm_edge;
  // hold-timer FSM; timer restarts from zero whenever the state changes
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE:    if (ir_detected) state_d = CONFIRM;
      CONFIRM: if (!ir_detected) state_d = IDLE;
               else if (timer_q == TIMER_W'(CONFIRM_CYCLES - 1)) state_d = PRESENT;
               else timer_d = timer_q + TIMER_W'(1);
      PRESENT: if (!ir_detected) state_d = RELEASE;
      RELEASE: if (ir_detected) state_d = PRESENT;
               else if (timer_q == TIMER_W'(RELEASE_CYCLES - 1)) state_d = IDLE;
               else timer_d = timer_q + TIMER_W'(1);
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
    confirm_edge = state_q == CONFIRM && state_d == PRESENT;
    present_d = state_d == PRESENT || state_d == RELEASE;
    obj_event_d = confirm_edge;
  end
  // state, timer and registered presence/event outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      present_q <= 1'b0;
      obj_event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      present_q <= present_d;
      obj_event_q <= obj_event_d;
    end
  end
  sat_counter #(.W(COUNT_W)) u_obj_cnt (
    .clk(clk), .reset(reset), .clr(clear), .inc(confirm_edge), .cnt(obj_count), .sat(count_sat)
  );
  assign present = present_q;
  assign led = present_q;
  assign obj_event = obj_event_q;
`ifdef IR_PRESENCE_DWELL_EN
  logic [DWELL_W-1:0] dwell_cnt, dwell_cycles_q, dwell_cycles_d;
  logic dwell_sat, dwell_valid_q, dwell_valid_d, release_edge;
  sat_counter #(.W(DWELL_W)) u_dwell_cnt (
    .clk(clk), .reset(reset), .clr(confirm_edge), .inc(present_d && (confirm_edge || !dwell_sat)),
    .cnt(dwell_cnt), .sat(dwell_sat)
  );
  // latch the running dwell count when the object finally leaves
  always_comb begin
    release_edge = state_q == RELEASE && state_d == IDLE;
    dwell_cycles_d = release_edge ? dwell_cnt : dwell_cycles_q;
    dwell_valid_d = release_edge;
  end
  // dwell result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_cycles_q <= '0;
      dwell_valid_q <= 1'b0;
    end else begin
      dwell_cycles_q <= dwell_cycles_d;
      dwell_valid_q <= dwell_valid_d;
    end
  end
  assign dwell_cycles = dwell_cycles_q;
  assign dwell_valid = dwell_valid_q;
`else
  assign dwell_cycles = '0;
  assign dwell_valid = 1'b0;
`endif
endmodule

// File: tb/tb_ir_presence_counter.sv
// tb_ir_presence_counter: directed plus randomized checks against a run-length reference model
module tb_ir_presence_counter;
  import ir_pkg::*;
  localparam int C = 4;
  localparam int R = 3;
  localparam int CW = 4;
  localparam int DW = 24;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, reset = 1'b0, ir_detected = 1'b0, clear = 1'b0;
  logic present, led, obj_event, count_sat, dwell_valid;
  logic [CW-1:0] obj_count;
  logic [DW-1:0] dwell_cycles;
  int checks = 0, errors = 0;
  int hi, lo, m_count, m_dwell, m_run;
  bit m_present, m_sat, m_ev, m_dv;
  int pres_n = 0, ev_n = 0, dv_n = 0;

  always #5 clk = ~clk;

  ir_presence_counter #(
    .CONFIRM_CYCLES(C), .RELEASE_CYCLES(R), .COUNT_W(CW), .TIMER_W(16), .DWELL_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .ir_detected(ir_detected), .clear(clear),
    .present(present), .led(led), .obj_event(obj_event), .obj_count(obj_count),
    .count_sat(count_sat), .dwell_cycles(dwell_cycles), .dwell_valid(dwell_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hi = 0; lo = 0; m_count = 0; m_sat = 0; m_present = 0;
    m_ev = 0; m_dv = 0; m_dwell = 0; m_run = 0;
  endtask

  // object confirmed after C+1 consecutive high samples, released after R+1 consecutive low samples
  task automatic model_step(input bit ir, input bit clr);
    m_ev = 0; m_dv = 0;
    if (ir) begin hi++; lo = 0; end else begin lo++; hi = 0; end
    if (clr) begin m_count = 0; m_sat = 0; end
    if (!m_present && hi == C + 1) begin
      m_present = 1; m_ev = 1; m_run = 0;
      if (m_count < CMAX) m_count++;
      if (m_count == CMAX) m_sat = 1;
    end else if (m_present && lo == R + 1) begin
      m_present = 0; m_dv = 1; m_dwell = m_run;
    end
    if (m_present) m_run++;
  endtask

  task automatic check_all();
    chk("present", 32'(present), 32'(m_present));
    chk("led", 32'(led), 32'(m_present));
    chk("obj_event", 32'(obj_event), 32'(m_ev));
    chk("obj_count", 32'(obj_count), m_count);
    chk("count_sat", 32'(count_sat), 32'(m_sat));
`ifdef IR_PRESENCE_DWELL_EN
    chk("dwell_valid", 32'(dwell_valid), 32'(m_dv));
    chk("dwell_cycles", 32'(dwell_cycles), m_dwell);
`else
    chk("dwell_valid", 32'(dwell_valid), 0);
    chk("dwell_cycles", 32'(dwell_cycles), 0);
`endif
  endtask

  task automatic cyc(input bit ir, input bit clr);
    ir_detected = ir; clear = clr;
    @(posedge clk);
    if (!reset) model_reset(); else model_step(ir, clr);
    @(negedge clk);
    check_all();
    pres_n += int'(present); ev_n += int'(obj_event); dv_n += int'(dwell_valid);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    repeat (3) cyc(0, 0);
    reset = 1'b1;
    repeat (6) cyc(1, 0);
    chk("pre_reset_present", 32'(present), 1);
    // reset mid-run with inputs toggling
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc(i % 2 == 0, i % 3 == 0);
    reset = 1'b1;
    #1 chk("state_after_reset", 32'(dut.state_q), 32'(IDLE));
    cyc(0, 0);
    // glitch of C samples, then a real arrival
    pres_n = 0; ev_n = 0;
    repeat (4) cyc(1, 0);
    repeat (3) cyc(0, 0);
    chk("glitch_events", ev_n, 0);
    chk("glitch_present", pres_n, 0);
    chk("glitch_count", 32'(obj_count), 0);
    repeat (4) cyc(1, 0);
    chk("arrive_early", 32'(present), 0);
    cyc(1, 0);
    chk("arrive_present", 32'(present), 1);
    chk("arrive_led", 32'(led), 1);
    chk("arrive_events", ev_n, 1);
    chk("arrive_count", 32'(obj_count), 1);
    // short dropout is held, long one releases
    repeat (3) cyc(0, 0);
    cyc(1, 0);
    chk("gap_present", 32'(present), 1);
    chk("gap_count", 32'(obj_count), 1);
    repeat (3) cyc(0, 0);
    chk("depart_early", 32'(present), 1);
    cyc(0, 0);
    chk("depart_present", 32'(present), 0);
    // saturation and clear
    cyc(0, 1);
    chk("clear_count", 32'(obj_count), 0);
    for (int k = 1; k <= 16; k++) begin
      repeat (5) cyc(1, 0);
      if (k == 15) begin
        chk("sat_count", 32'(obj_count), 15);
        chk("sat_flag", 32'(count_sat), 1);
      end
      if (k == 16) begin
        chk("sat_event", 32'(obj_event), 1);
        chk("sat_hold", 32'(obj_count), 15);
      end
      repeat (4) cyc(0, 0);
    end
    cyc(0, 1);
    chk("clr_count", 32'(obj_count), 0);
    chk("clr_sat", 32'(count_sat), 0);
    repeat (4) cyc(1, 0);
    cyc(1, 1);
    chk("clr_confirm_count", 32'(obj_count), 1);
    chk("clr_confirm_sat", 32'(count_sat), 0);
    repeat (4) cyc(0, 0);
    // dwell of a 10-cycle object
    pres_n = 0; dv_n = 0;
    repeat (10) cyc(1, 0);
    repeat (5) cyc(0, 0);
    chk("dwell_present_cycles", pres_n, 9);
`ifdef IR_PRESENCE_DWELL_EN
    chk("dwell_pulses", dv_n, 1);
    chk("dwell_value", 32'(dwell_cycles), 9);
`else
    chk("dwell_pulses", dv_n, 0);
    chk("dwell_value", 32'(dwell_cycles), 0);
`endif
    // async reset while present
    repeat (6) cyc(1, 0);
    chk("pre_async_present", 32'(present), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_present", 32'(present), 0);
    chk("async_led", 32'(led), 0);
    chk("async_count", 32'(obj_count), 0);
    chk("async_dwell", 32'(dwell_cycles), 0);
    model_reset();
    cyc(1, 0);
    reset = 1'b1;
    ev_n = 0;
    repeat (4) cyc(1, 0);
    chk("reconfirm_early", ev_n, 0);
    cyc(1, 0);
    chk("reconfirm_event", 32'(obj_event), 1);
    chk("reconfirm_count", 32'(obj_count), 1);
    // randomized runs with occasional clears
    for (int n = 0; n < 120; n++) begin
      int len = int'($urandom_range(1, 7));
      bit lvl = n[0];
      for (int j = 0; j < len; j++) cyc(lvl, $urandom_range(0, 19) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ir_presence_counter.md
# ir_presence_counter

Downstream consumer of the IR detector stage. It takes the registered `ir_detected` level, filters dropouts with confirm/release hold timers, and turns the filtered level into a stable presence flag. It also emits a one-cycle event per object and keeps a saturating object count. It drives the status LED from the filtered presence instead of the raw detector, and feeds the object count to the rest of the system.

## Interface
- `CONFIRM_CYCLES`, default 1000: consecutive high cycles required beyond the first sample to confirm an object; minimum 1.
- `RELEASE_CYCLES`, default 1000: consecutive low cycles required beyond the first sample to release; minimum 1.
- `COUNT_W`, default 16: object counter width.
- `TIMER_W`, default 16: hold timer width; must hold max(CONFIRM_CYCLES, RELEASE_CYCLES)-1.
- `DWELL_W`, default 24: dwell measurement width.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ir_detected`  in  1  detector output; already in the `clk` domain, no synchroniser.
- `clear`  in  1  synchronous clear of `obj_count` and `count_sat`.
- `present`  out  1  filtered presence level.
- `led`  out  1  equals `present`.
- `obj_event`  out  1  one-cycle pulse per confirmed arrival.
- `obj_count`  out  COUNT_W  saturating arrival count.
- `count_sat`  out  1  sticky saturation flag.
- `dwell_cycles`  out  DWELL_W  last object's presence duration.
- `dwell_valid`  out  1  one-cycle pulse when `dwell_cycles` updates.

## Operation
- FSM states are IDLE, CONFIRM, PRESENT and RELEASE. `timer` is zeroed on every state entry.
- IDLE:
  - `ir_detected`=1 → CONFIRM.
- CONFIRM:
  - `ir_detected`=0 → IDLE, with no event.
  - Otherwise, if `timer`==CONFIRM_CYCLES-1 → PRESENT; else `timer`++.
- PRESENT:
  - `ir_detected`=0 → RELEASE.
- RELEASE:
  - `ir_detected`=1 → PRESENT, with no new event and no count.
  - Otherwise, if `timer`==RELEASE_CYCLES-1 → IDLE; else `timer`++.
- `present`/`led` are 1 exactly while the state is PRESENT or RELEASE.
- On the CONFIRM→PRESENT transition edge:
  - `obj_event` is registered high for one cycle.
  - `obj_count` increments.
- Saturation:
  - At all-ones, `obj_count` holds and `count_sat` sets.
  - `count_sat` is sticky until `clear` or reset.
  - `obj_event` still pulses while saturated.
- `clear` zeroes `obj_count` and `count_sat`.
  - If `clear` coincides with a confirm edge, the result is `obj_count`=1 (clear, then increment).
  - `clear` never affects the FSM, `present` or dwell.
- Reset mid-operation:
  - All state and outputs go to 0 immediately.
  - An object still in view after reset must re-confirm fully and is counted again.

## Timing
- Reset values: every output 0, state IDLE, `timer` 0.
- Arrival latency: `present` and `obj_event` rise in the cycle after `ir_detected` has been sampled high on CONFIRM_CYCLES+1 consecutive edges.
- Departure latency: `present` falls in the cycle after `ir_detected` has been sampled low on RELEASE_CYCLES+1 consecutive edges.
- Glitch rejection:
  - A high pulse of ≤CONFIRM_CYCLES samples produces nothing.
  - A low gap of ≤RELEASE_CYCLES samples does not drop `present`.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `IR_PRESENCE_DWELL_EN` defined:
  - A DWELL_W counter starts at 1 in the first cycle `present` is 1 and increments each cycle while `present` is 1, saturating at all-ones.
  - On the RELEASE→IDLE edge, the counter value is copied to `dwell_cycles` and `dwell_valid` pulses for one cycle alongside `present` falling.
  - `dwell_cycles` therefore equals the number of cycles `present` was 1.
- Undefined:
  - No dwell counter is built.
  - `dwell_cycles` and `dwell_valid` are tied to 0.
  - The port list is unchanged.

## Structure
- Package `ir_pkg` holds:
  - the `ir_presence_state_t` enum (IDLE, CONFIRM, PRESENT, RELEASE);
  - the default constants for CONFIRM_CYCLES, RELEASE_CYCLES and COUNT_W.
- Sub-module `sat_counter` (parameterised width, synchronous clear, increment enable, saturation flag) is instantiated for `obj_count` and, when enabled, for the dwell counter.

## Test plan
Bench parameters: CONFIRM_CYCLES=4, RELEASE_CYCLES=3, COUNT_W=4, macro defined.

1. Assert `reset` low mid-run with inputs toggling:
   - all outputs read 0 during and after reset;
   - the first cycle after release shows state IDLE.
2. Drive `ir_detected` high for 4 cycles, then low:
   - no `obj_event`, `obj_count`=0, `present` never rises.
   - Then drive it high for 5 cycles:
     - exactly one `obj_event` pulse;
     - `obj_count`=1;
     - `present`=`led`=1 in the 6th cycle.
3. While PRESENT, drop `ir_detected` for 3 cycles, then restore it high:
   - `present` stays 1, `obj_count` is unchanged.
   - Then drop it for 4 cycles:
     - `present` falls in the 5th cycle.
4. Confirm 16 objects:
   - `obj_count`=15, `count_sat`=1 after the 15th;
   - the 16th still pulses `obj_event`.
   - Pulse `clear`: `obj_count`=0, `count_sat`=0.
   - Then pulse `clear` on the same edge as a confirm: `obj_count`=1.
5. Drive `ir_detected` high for 10 cycles, then low:
   - `present` is 1 for 9 cycles;
   - `dwell_valid` pulses once;
   - `dwell_cycles`=9.
6. Assert async reset while in PRESENT:
   - `present`, `led`, `obj_count` and `dwell_cycles` go to 0 before the next clock edge.
   - With `ir_detected` still high after reset release, a new `obj_event` follows 5 sampled cycles and `obj_count`=1.
